// File: rtl/arduino_rx_serial.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | arduino_rx_serial : start + 7 data (LSB first) + even parity + stop        |
// | receiver for frames from the Arduino board.   Rev 1.0                      |
// +---------------------------------------------------------------------------+
module arduino_rx_serial #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       rx,
  output logic [6:0] dado,
  output logic       dado_valido,
  output logic       nota_unica,
  output logic       erro_paridade,
  output logic       erro_frame,
  output logic       ocupado
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [2:0]       idx, idx_n;
  logic [6:0]       shift, shift_n;
  logic             par_bit, par_n;
  logic             valid_n, perr_n, ferr_n;
  logic             rx_meta, rx_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      count         <= '0;
      idx           <= '0;
      shift         <= '0;
      par_bit       <= 1'b0;
      dado          <= '0;
      nota_unica    <= 1'b0;
      dado_valido   <= 1'b0;
      erro_paridade <= 1'b0;
      erro_frame    <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_s          <= rx_meta;
      state         <= state_n;
      count         <= count_n;
      idx           <= idx_n;
      shift         <= shift_n;
      par_bit       <= par_n;
      dado_valido   <= valid_n;
      erro_paridade <= perr_n;
      erro_frame    <= ferr_n;
      if (valid_n) begin
        dado       <= shift;
        nota_unica <= ($countones(shift) == 1);
      end
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par_bit;
    valid_n = 1'b0;
    perr_n  = 1'b0;
    ferr_n  = 1'b0;
    if (!habilita) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          count_n = '0;
          if (!rx_s) state_n = START;
        end
        // Mid-bit recheck rejects glitches shorter than half a bit.
        START: begin
          if (count == HALF_LAST) begin
            count_n = '0;
            idx_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        DATA: begin
          if (count == BIT_LAST) begin
            count_n      = '0;
            shift_n[idx] = rx_s;
            if (idx == 3'd6) state_n = PARITY;
            else             idx_n   = idx + 3'd1;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        PARITY: begin
          if (count == BIT_LAST) begin
            count_n = '0;
            par_n   = rx_s;
            state_n = STOP;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        // Leaving at mid-stop lets a back-to-back start bit be caught.
        STOP: begin
          if (count == BIT_LAST) begin
            count_n = '0;
            if (!rx_s) begin
              ferr_n  = 1'b1;
              state_n = WAIT_IDLE;
            end else begin
              state_n = IDLE;
              if (^{shift, par_bit}) perr_n  = 1'b1;
              else                   valid_n = 1'b1;
            end
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          count_n = '0;
          if (rx_s) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  assign ocupado = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_arduino_rx_serial.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_arduino_rx_serial : directed + random frames against a frame-level model|
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_arduino_rx_serial;

  localparam int BIT = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b1;
  logic       rx = 1'b1;
  logic [6:0] dado;
  logic       dado_valido, nota_unica, erro_paridade, erro_frame, ocupado;

  arduino_rx_serial #(.CLKS_PER_BIT(BIT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .rx(rx),
    .dado(dado), .dado_valido(dado_valido), .nota_unica(nota_unica),
    .erro_paridade(erro_paridade), .erro_frame(erro_frame), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  int checks = 0, passes = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, bad_pulse = 0;
  int cyc = 0, last_v = 0, prev_v = 0, lat = 0;
  logic pv = 0, pp = 0, pf = 0;

  // Observed pulse bookkeeping, sampled mid-cycle.
  always @(negedge clock) begin
    cyc++;
    if (int'(dado_valido) + int'(erro_paridade) + int'(erro_frame) > 1) bad_pulse++;
    if ((dado_valido && pv) || (erro_paridade && pp) || (erro_frame && pf)) bad_pulse++;
    if (dado_valido) begin n_valid++; prev_v = last_v; last_v = cyc; end
    if (erro_paridade) n_perr++;
    if (erro_frame) n_ferr++;
    pv = dado_valido; pp = erro_paridade; pf = erro_frame;
  end

  // Frame-level reference: outcome follows from stop bit, then parity count.
  logic [6:0] exp_dado = '0;
  logic       exp_nota = 1'b0;
  int exp_valid = 0, exp_perr = 0, exp_ferr = 0;

  function automatic int ones(input logic [6:0] d);
    int n = 0;
    for (int i = 0; i < 7; i++) n += int'(d[i]);
    return n;
  endfunction

  task automatic model_frame(input logic [6:0] d, input logic p, input logic s);
    if (!s) exp_ferr++;
    else if ((ones(d) + int'(p)) % 2 != 0) exp_perr++;
    else begin
      exp_valid++;
      exp_dado = d;
      exp_nota = (ones(d) == 1);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/dado"}, 32'(dado), 32'(exp_dado));
    chk({tag, "/nota_unica"}, 32'(nota_unica), 32'(exp_nota));
    chk({tag, "/valid_count"}, n_valid, exp_valid);
    chk({tag, "/perr_count"}, n_perr, exp_perr);
    chk({tag, "/ferr_count"}, n_ferr, exp_ferr);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [6:0] rd;
    logic       rp, rs;

    // 1: reset state, then a single-note frame with latency measurement
    repeat (3) @(negedge clock);
    chk("t1/rst_dado", 32'(dado), 0);
    chk("t1/rst_flags", {28'd0, dado_valido, erro_paridade, erro_frame, nota_unica}, 0);
    chk("t1/rst_ocupado", 32'(ocupado), 0);
    reset = 1'b0;
    idle(20);
    fork
      send_frame(7'b0000100, 1'b1, 1'b1);
      begin
        lat = 0;
        while (dado_valido !== 1'b1 && lat < 200) begin
          @(posedge clock); lat++; #1;
        end
        chk("t1/latency", lat, 79);
        @(posedge clock); #1;
        chk("t1/pulse_width", 32'(dado_valido), 0);
      end
    join
    model_frame(7'b0000100, 1'b1, 1'b1);
    idle(4);
    check_state("t1");

    // 2: false start
    rx = 1'b0;
    repeat (3) @(negedge clock);
    chk("t2/ocupado_in_start", 32'(ocupado), 1);
    idle(6);
    chk("t2/ocupado_dropped", 32'(ocupado), 0);
    check_state("t2");

    // 3: parity error
    send_frame(7'b0000011, 1'b1, 1'b1);
    model_frame(7'b0000011, 1'b1, 1'b1);
    idle(4);
    check_state("t3");

    // 4: framing error with line held low, then recovery
    send_frame(7'b1000000, 1'b1, 1'b0);
    model_frame(7'b1000000, 1'b1, 1'b0);
    repeat (30) @(negedge clock);
    chk("t4/ocupado_held", 32'(ocupado), 1);
    idle(8);
    chk("t4/ocupado_released", 32'(ocupado), 0);
    check_state("t4a");
    send_frame(7'b0100000, 1'b1, 1'b1);
    model_frame(7'b0100000, 1'b1, 1'b1);
    idle(4);
    check_state("t4b");

    // 5: back-to-back frames
    send_frame(7'b0000001, 1'b1, 1'b1);
    send_frame(7'b0000011, 1'b0, 1'b1);
    model_frame(7'b0000001, 1'b1, 1'b1);
    model_frame(7'b0000011, 1'b0, 1'b1);
    idle(4);
    chk("t5/pulse_spacing", last_v - prev_v, 80);
    check_state("t5");

    // 6a: reset during data bit 3
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rx = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    exp_dado = '0;
    exp_nota = 1'b0;
    chk("t6/rst_outputs", {dado, dado_valido, erro_paridade, erro_frame, nota_unica, ocupado}, 0);
    reset = 1'b0;
    idle(5);
    send_frame(7'b0010000, 1'b1, 1'b1);
    model_frame(7'b0010000, 1'b1, 1'b1);
    idle(4);
    check_state("t6a");

    // 6b: enable dropped mid-frame; rest of the frame is ignored
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    habilita = 1'b0;
    repeat (2) @(negedge clock);
    chk("t6/ocupado_disabled", 32'(ocupado), 0);
    repeat (3) @(negedge clock);
    for (int i = 3; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(4);
    habilita = 1'b1;
    idle(4);
    check_state("t6b");

    // Random frames: mostly good, some parity and framing errors
    for (int f = 0; f < 12; f++) begin
      rd = 7'($urandom);
      rp = 1'((ones(rd) % 2) ^ int'($urandom_range(0, 3) == 0));
      rs = ($urandom_range(0, 7) != 0);
      send_frame(rd, rp, rs);
      model_frame(rd, rp, rs);
      idle($urandom_range(4, 9));
      check_state($sformatf("rnd%0d", f));
    end

    chk("pulse_rules", bad_pulse, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arduino_rx_serial.md
Name: arduino_rx_serial

Overview:
- Serial receiver on the FPGA for frames sent by the Arduino sound/interface board. It is the return path of the FPGA-to-Arduino note link.
- Deserialises one 8N-style frame: start bit, 7 data bits (LSB first), even parity, stop bit.
- Delivers the 7-bit note/button vector with a one-cycle valid pulse and error flags to the game control unit.
- Sits beside the arduino_out transmitter in the datapath; its outputs feed the control FSM the same way botoes does.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be even and >= 4.
- CNT_W, 13, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- habilita  input  1  receiver enable; low forces IDLE.
- rx  input  1  serial line from Arduino; idle high; asynchronous to clock.
- dado  output  7  last correctly received data word.
- dado_valido  output  1  one-cycle pulse when dado is updated.
- nota_unica  output  1  registered; 1 when dado has exactly one bit set.
- erro_paridade  output  1  one-cycle pulse on parity mismatch.
- erro_frame  output  1  one-cycle pulse when the stop bit samples 0.
- ocupado  output  1  high in every state except IDLE.

Behaviour:
- Reset (async) values:
  - dado=0, nota_unica=0, dado_valido=0, erro_paridade=0, erro_frame=0, ocupado=0.
  - FSM=IDLE, counter=0, shift register=0.
  - Both synchroniser flops=1.
- Synchroniser: rx passes through 2 flops; the FSM sees only rx_s. This adds 2 cycles of latency.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - Enter START with counter=0 when habilita=1 and rx_s=0.
  - Otherwise stay in IDLE.
- START (mid-bit check):
  - At counter=CLKS_PER_BIT/2-1, sample rx_s.
  - rx_s=0: go to DATA, counter=0, bit index=0.
  - rx_s=1: false start; return to IDLE with no flags.
- DATA:
  - At counter=CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first) and reset counter.
  - After index 6, go to PARITY.
- PARITY:
  - At counter=CLKS_PER_BIT-1, sample the parity bit.
  - Required parity: XOR of the 7 data bits XOR parity bit == 0 (even).
- STOP: at counter=CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 and parity ok: dado<=shift, nota_unica<=popcount(shift)==1, dado_valido=1 for the next cycle; go to IDLE.
  - rx_s=1 and parity bad: erro_paridade pulse; dado and nota_unica unchanged; go to IDLE.
  - rx_s=0: erro_frame pulse (takes priority over parity); dado unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a held-low line from being re-read as a start bit.
- Sample timing: with t0 = first cycle the FSM sees rx_s=0, sample k (start=0, data 1..7, parity 8, stop 9) occurs at t0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
- Latency: pin falling edge to dado_valido = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clock edges.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start bit immediately following the stop bit is accepted with no gap required.
- Pulses: dado_valido, erro_paridade and erro_frame are never high together and never high for more than one cycle.
- habilita=0 mid-frame: abort to IDLE next edge, counter cleared, no flags, dado unchanged.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- Counter: never exceeds CLKS_PER_BIT-1; no wrap beyond it.

Test Plan (CLKS_PER_BIT=8; bench drives rx bit-by-bit, 8 cycles per bit):
1. Reset, idle 20 cycles, send data 7'b0000100 with parity=1 and stop=1 -> dado_valido high for exactly one cycle, 79 edges after the rx falling edge; dado=7'b0000100, nota_unica=1, no error flags.
2. Drive rx low for 3 cycles then high -> FSM returns to IDLE; ocupado drops within 6 cycles; no pulses; dado unchanged.
3. After scenario 1, send 7'b0000011 with parity=1 -> erro_paridade one-cycle pulse; dado stays 7'b0000100; dado_valido never asserted.
4. Send 7'b1000000 with stop=0, hold rx low 30 more cycles, then release; then send 7'b0100000 -> erro_frame pulse once; ocupado stays high while rx is held low; second frame yields dado=7'b0100000, nota_unica=1.
5. Send two frames back-to-back with no idle gap (7'b0000001 then 7'b0000011, correct parity) -> two dado_valido pulses 80 cycles apart; final dado=7'b0000011, nota_unica=0.
6. Assert reset during data bit 3, release, send 7'b0010000 -> all outputs 0 during reset; next frame received correctly. Repeat with habilita=0 during a frame -> no pulses.
